// File: rtl/fanout_tree_pipe.sv
// Registered fanout tree. One source stream is copied down a balanced tree of
// valid/data registers, so no register drives more than FANOUT loads.
module fanout_tree_pipe #(
  parameter int WIDTH      = 8,
  parameter int NUM_SINKS  = 20,
  parameter int FANOUT     = 4,
  parameter int TREE_DEPTH = 3,
  parameter int CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  input  logic                       stall,
  input  logic                       cfg_we,
  input  logic [NUM_SINKS-1:0]       cfg_mask,
  output logic [NUM_SINKS-1:0]       out_valid,
  output logic [NUM_SINKS*WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]           beat_count
);

  function automatic int ipow(input int b, input int e);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  // Level l holds one node per group of FANOUT^(TREE_DEPTH-l) sinks.
  function automatic int level_nodes(input int l);
    int p;
    p = ipow(FANOUT, TREE_DEPTH - l);
    return (NUM_SINKS + p - 1) / p;
  endfunction

  if (NUM_SINKS < 2) begin : g_bad_sinks
    $error("fanout_tree_pipe: NUM_SINKS must be at least 2");
  end
  if (FANOUT < 2) begin : g_bad_fanout
    $error("fanout_tree_pipe: FANOUT must be at least 2");
  end
  if (ipow(FANOUT, TREE_DEPTH) < NUM_SINKS) begin : g_bad_depth
    $error("fanout_tree_pipe: FANOUT**TREE_DEPTH is smaller than NUM_SINKS");
  end

  // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
  // in_ready is simply !stall, and downstream sinks never push back.
  assign in_ready = ~stall;

  logic accept;
  assign accept = in_valid & ~stall;

  for (genvar l = 0; l <= TREE_DEPTH; l++) begin : g_lvl
    localparam int N = level_nodes(l);

    logic [N-1:0]     v;
    logic [WIDTH-1:0] d  [N];
    logic [N-1:0]     pv;
    logic [WIDTH-1:0] pd [N];

    if (l == 0) begin : g_root
      assign pv    = in_valid;
      assign pd[0] = in_data;
    end else begin : g_child
      always_comb begin
        pv = '0;
        for (int j = 0; j < N; j++) begin
          pv[j] = g_lvl[l-1].v[j / FANOUT];
          pd[j] = g_lvl[l-1].d[j / FANOUT];
        end
      end
    end

    // Data only loads behind a valid parent, so it holds through bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v <= '0;
        for (int j = 0; j < N; j++) d[j] <= '0;
      end else if (!stall) begin
        v <= pv;
        for (int j = 0; j < N; j++) begin
          if (pv[j]) d[j] <= pd[j];
        end
      end
    end
  end

  logic [NUM_SINKS-1:0] sink_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sink_en <= '1;
    end else if (cfg_we) begin
      sink_en <= cfg_mask;
    end
  end

  // The mask gates the leaf valids combinationally so it also hides beats
  // already sitting in the leaves.
  assign out_valid = g_lvl[TREE_DEPTH].v & sink_en;

  for (genvar i = 0; i < NUM_SINKS; i++) begin : g_out
    assign out_data[i*WIDTH +: WIDTH] = g_lvl[TREE_DEPTH].d[i];
  end

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (accept && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign beat_count = cnt;

endmodule
